// File: rtl/aes_stream_arbiter_if.sv
// Bundles the requester, controller and response streams that the arbiter sits between.
// The arbiter uses the slave view; the surrounding fabric (or a bench) uses the master view.
interface aes_stream_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_pending;
    logic [NUM_REQ-1:0]            req_wren;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_tlast;
    logic [NUM_REQ-1:0]            req_busy;

    logic                          in_bus_data_wren;
    logic [DATA_WIDTH-1:0]         in_bus_data;
    logic                          in_bus_tlast;
    logic                          controller_in_busy;

    logic                          out_bus_tvalid;
    logic [DATA_WIDTH-1:0]         out_bus_tdata;
    logic                          out_bus_tlast;
    logic                          out_bus_tready;

    logic [NUM_REQ-1:0]            rsp_tvalid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_tdata;
    logic [NUM_REQ-1:0]            rsp_tlast;
    logic [NUM_REQ-1:0]            rsp_tready;

    modport slave (
        input  req_pending, req_wren, req_data, req_tlast,
        output req_busy,
        output in_bus_data_wren, in_bus_data, in_bus_tlast,
        input  controller_in_busy,
        input  out_bus_tvalid, out_bus_tdata, out_bus_tlast,
        output out_bus_tready,
        output rsp_tvalid, rsp_tdata, rsp_tlast,
        input  rsp_tready
    );

    modport master (
        output req_pending, req_wren, req_data, req_tlast,
        input  req_busy,
        input  in_bus_data_wren, in_bus_data, in_bus_tlast,
        output controller_in_busy,
        output out_bus_tvalid, out_bus_tdata, out_bus_tlast,
        input  out_bus_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tlast,
        output rsp_tready
    );
endinterface

// File: rtl/aes_stream_arbiter.sv
// Round-robin, packet-granular sharing of one AES controller between NUM_REQ requesters;
// an order FIFO of grants steers the in-order controller output back to each packet's owner.
module aes_stream_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    aes_stream_arbiter_if.slave   bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int PW = $clog2(ORDER_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         order_mem_q [ORDER_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    logic                  fifo_empty, fifo_full, push, pop, passing;
    logic [GW-1:0]         head;
    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;
    logic                  sel_wren, sel_tlast;
    logic [DATA_WIDTH-1:0] sel_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(ORDER_DEPTH));
    assign head       = order_mem_q[rd_ptr_q];

    // Outputs are forced to their reset values while resetn is low, not only after the edge.
    assign passing = resetn & (state_q == PASS);

    // First pending requester at or after rr_ptr, searching cyclically.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_valid && bus.req_pending[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        sel_wren  = 1'b0;
        sel_tlast = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_wren  = bus.req_wren[i];
                sel_tlast = bus.req_tlast[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_bus_data_wren = passing & sel_wren & ~bus.controller_in_busy;
    assign bus.in_bus_data      = sel_data;
    assign bus.in_bus_tlast     = passing & sel_tlast;

    assign push = bus.in_bus_data_wren & sel_tlast;
    assign bus.out_bus_tready = resetn & ~fifo_empty & bus.rsp_tready[head];
    assign pop  = bus.out_bus_tready & bus.out_bus_tvalid & bus.out_bus_tlast;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic route;
        assign route = resetn & ~fifo_empty & (head == GW'(gi)) & bus.out_bus_tvalid;
        assign bus.req_busy[gi]   = ~passing | (grant_q != GW'(gi)) | bus.controller_in_busy;
        assign bus.rsp_tvalid[gi] = route;
        assign bus.rsp_tlast[gi]  = route & bus.out_bus_tlast;
        assign bus.rsp_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = bus.out_bus_tdata;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && !fifo_full) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (push) begin
                    rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entries are only read when the count says they were written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) order_mem_q[wr_ptr_q] <= grant_q;
    end
endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Directed bench for aes_stream_arbiter: vector table for the main flows, hand sequences
// for the full-FIFO, back-pressure and mid-packet reset cases.
module tb_aes_stream_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int OD = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aes_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    aes_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ORDER_DEPTH(OD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        rstn;
        logic [1:0]  pend, wren, tlast;
        logic [31:0] d0, d1;
        logic        cbusy, otv;
        logic [31:0] otd;
        logic        otl;
        logic [1:0]  rrdy;
        logic [1:0]  e_busy;
        logic        e_wren;
        logic [31:0] e_data;
        logic        e_itlast, e_tready;
        logic [1:0]  e_rv, e_rl;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic rstn, input logic [1:0] pend, input logic [1:0] wren, input logic [1:0] tlast,
        input logic [31:0] d0, input logic [31:0] d1, input logic cbusy, input logic otv,
        input logic [31:0] otd, input logic otl, input logic [1:0] rrdy,
        input logic [1:0] e_busy, input logic e_wren, input logic [31:0] e_data,
        input logic e_itlast, input logic e_tready, input logic [1:0] e_rv, input logic [1:0] e_rl);
        vec_t v;
        v.rstn = rstn; v.pend = pend; v.wren = wren; v.tlast = tlast;
        v.d0 = d0; v.d1 = d1; v.cbusy = cbusy; v.otv = otv; v.otd = otd; v.otl = otl;
        v.rrdy = rrdy; v.e_busy = e_busy; v.e_wren = e_wren; v.e_data = e_data;
        v.e_itlast = e_itlast; v.e_tready = e_tready; v.e_rv = e_rv; v.e_rl = e_rl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        resetn                 = v.rstn;
        bus.req_pending        = v.pend;
        bus.req_wren           = v.wren;
        bus.req_tlast          = v.tlast;
        bus.req_data           = {v.d1, v.d0};
        bus.controller_in_busy = v.cbusy;
        bus.out_bus_tvalid     = v.otv;
        bus.out_bus_tdata      = v.otd;
        bus.out_bus_tlast      = v.otl;
        bus.rsp_tready         = v.rrdy;
        #1;
        chk($sformatf("%s req_busy", tag), 64'(bus.req_busy), 64'(v.e_busy));
        chk($sformatf("%s in_wren", tag), 64'(bus.in_bus_data_wren), 64'(v.e_wren));
        if (v.e_wren) begin
            chk($sformatf("%s in_data", tag), 64'(bus.in_bus_data), 64'(v.e_data));
            chk($sformatf("%s in_tlast", tag), 64'(bus.in_bus_tlast), 64'(v.e_itlast));
        end
        chk($sformatf("%s out_tready", tag), 64'(bus.out_bus_tready), 64'(v.e_tready));
        chk($sformatf("%s rsp_tvalid", tag), 64'(bus.rsp_tvalid), 64'(v.e_rv));
        chk($sformatf("%s rsp_tlast", tag), 64'(bus.rsp_tlast), 64'(v.e_rl));
        chk($sformatf("%s rsp_tdata", tag), 64'(bus.rsp_tdata), {v.otd, v.otd});
        $display("vec %s busy=%b wren=%b data=%h tready=%b rsp_tvalid=%b rsp_tlast=%b",
                 tag, bus.req_busy, bus.in_bus_data_wren, bus.in_bus_data,
                 bus.out_bus_tready, bus.rsp_tvalid, bus.rsp_tlast);
    endtask

    function automatic vec_t rst_row();
        return mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00);
    endfunction

    function automatic vec_t idle_row(input logic [1:0] pend);
        return mk(1, pend, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00);
    endfunction

    vec_t        tbl[$];
    logic [31:0] got[$];
    logic [31:0] words[6];

    initial begin
        resetn = 1'b0;
        bus.req_pending = '0; bus.req_wren = '0; bus.req_tlast = '0; bus.req_data = '0;
        bus.controller_in_busy = 1'b0; bus.out_bus_tvalid = 1'b0; bus.out_bus_tdata = '0;
        bus.out_bus_tlast = 1'b0; bus.rsp_tready = '0;

        // single packet from requester 0, then its controller output
        tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 2'b01, 2'b01, (k == 3) ? 2'b01 : 2'b00, 32'hA000_0000 + k, 0, 0, 0, 0, 0,
                             2'b11, 2'b10, 1, 32'hA000_0000 + k, k == 3, 0, 2'b00, 2'b00));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hC000_0000 + k, k == 3, 2'b11,
                             2'b11, 0, 0, 0, 1, 2'b01, (k == 3) ? 2'b01 : 2'b00));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hC000_0004, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        // both pending: grants alternate 0,1,0,1 and fill the order FIFO
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        for (int p = 0; p < 4; p++) begin
            tbl.push_back(idle_row(2'b11));
            if (p % 2 == 0)
                tbl.push_back(mk(1, 2'b11, 2'b01, 2'b01, 32'hB000_0000 + p, 0, 0, 0, 0, 0, 2'b00,
                                 2'b10, 1, 32'hB000_0000 + p, 1, 0, 2'b00, 2'b00));
            else
                tbl.push_back(mk(1, 2'b11, 2'b10, 2'b10, 0, 32'hB000_0000 + p, 0, 0, 0, 0, 2'b00,
                                 2'b01, 1, 32'hB000_0000 + p, 1, 0, 2'b00, 2'b00));
        end
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0000, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b01, 2'b01));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0001, 1, 2'b01, 2'b11, 0, 0, 0, 0, 2'b10, 2'b10));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0001, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b10, 2'b10));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0002, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b01, 2'b01));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0003, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b10, 2'b10));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hD000_0004, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));
        // push and pop land in the same cycle
        tbl.push_back(idle_row(2'b01));
        tbl.push_back(mk(1, 2'b01, 2'b01, 2'b01, 32'hE000_0000, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 32'hE000_0000, 1, 0, 2'b00, 2'b00));
        tbl.push_back(idle_row(2'b10));
        tbl.push_back(mk(1, 2'b10, 2'b10, 2'b10, 0, 32'hE000_0001, 0, 1, 32'hF000_0000, 1, 2'b11,
                         2'b01, 1, 32'hE000_0001, 1, 1, 2'b01, 2'b01));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hF000_0001, 1, 2'b11, 2'b11, 0, 0, 0, 1, 2'b10, 2'b10));
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'hF000_0002, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // order FIFO full: fifth packet waits until one response packet drains
        apply(rst_row(), "full.rst");
        for (int k = 0; k < 4; k++) begin
            apply(idle_row(2'b01), $sformatf("full.idle%0d", k));
            apply(mk(1, 2'b01, 2'b01, 2'b01, 32'h6000_0000 + k, 0, 0, 0, 0, 0, 2'b00,
                     2'b10, 1, 32'h6000_0000 + k, 1, 0, 2'b00, 2'b00), $sformatf("full.pkt%0d", k));
        end
        for (int j = 0; j < 3; j++) apply(idle_row(2'b01), $sformatf("full.block%0d", j));
        apply(mk(1, 2'b01, 0, 0, 0, 0, 0, 1, 32'h7000_0000, 1, 2'b01, 2'b11, 0, 0, 0, 1, 2'b01, 2'b01), "full.drain");
        apply(idle_row(2'b01), "full.regrant");
        apply(mk(1, 2'b01, 2'b01, 2'b01, 32'h6000_0004, 0, 0, 0, 0, 0, 2'b00,
                 2'b10, 1, 32'h6000_0004, 1, 0, 2'b00, 2'b00), "full.pkt4");

        // controller back-pressure toggling every other cycle during a 6-word packet
        apply(rst_row(), "bp.rst");
        apply(idle_row(2'b10), "bp.idle");
        for (int k = 0; k < 6; k++) words[k] = 32'h9000_0000 + k * 32'h11;
        begin
            int idx;
            idx = 0;
            for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
                @(negedge clk);
                bus.controller_in_busy = (cyc % 2 == 0);
                bus.req_wren  = 2'b10;
                bus.req_tlast = (idx == 5) ? 2'b10 : 2'b00;
                bus.req_data  = {words[idx], 32'h0};
                #1;
                chk($sformatf("bp%0d busy1", cyc), 64'(bus.req_busy[1]), 64'(cyc % 2 == 0));
                chk($sformatf("bp%0d busy0", cyc), 64'(bus.req_busy[0]), 64'd1);
                chk($sformatf("bp%0d wren", cyc), 64'(bus.in_bus_data_wren), 64'(cyc % 2 != 0));
                $display("bp cyc %0d busy=%b wren=%b data=%h", cyc, bus.req_busy,
                         bus.in_bus_data_wren, bus.in_bus_data);
                if (bus.in_bus_data_wren) begin
                    got.push_back(bus.in_bus_data);
                    idx++;
                end
            end
        end
        chk("bp word count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("bp word%0d", k), 64'(got[k]), 64'(words[k]));
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h9100_0000, 1, 2'b10, 2'b11, 0, 0, 0, 1, 2'b10, 2'b10), "bp.rsp");

        // reset asserted on word 2 of a 4-word packet
        apply(rst_row(), "mid.rst");
        apply(idle_row(2'b01), "mid.idle");
        apply(mk(1, 2'b01, 2'b01, 2'b00, 32'h8000_0000, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 32'h8000_0000, 0, 0, 2'b00, 2'b00), "mid.w1");
        apply(mk(0, 2'b01, 2'b01, 2'b00, 32'h8000_0001, 0, 0, 1, 32'h8800_0000, 0, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00), "mid.rstlow");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8800_0001, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00), "mid.after");
        apply(idle_row(2'b01), "mid.idle2");
        apply(mk(1, 2'b01, 2'b01, 2'b00, 32'h8100_0000, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 32'h8100_0000, 0, 0, 2'b00, 2'b00), "mid.n1");
        apply(mk(1, 2'b01, 2'b01, 2'b01, 32'h8100_0001, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 32'h8100_0001, 1, 0, 2'b00, 2'b00), "mid.n2");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8200_0000, 0, 2'b01, 2'b11, 0, 0, 0, 1, 2'b01, 2'b00), "mid.r1");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8200_0001, 1, 2'b01, 2'b11, 0, 0, 0, 1, 2'b01, 2'b01), "mid.r2");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 32'h8200_0002, 1, 2'b11, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00), "mid.empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
